// File: rtl/sevenseg_scan_ctrl.sv
// Two-digit multiplexed seven-segment scan controller with frame-synchronous data swap.
// Latency: outputs are registered one cycle behind the slot counter; a write shows from the frame after the next frame boundary.
// Backpressure: none, data_valid is always accepted; the last write before a frame boundary wins.
// Optional build macro SEVENSEG_LZB_EN enables leading-zero blanking of digit 1.
module sevenseg_scan_ctrl #(
  parameter int PRESCALE     = 50000,  // clock cycles per digit slot, 4..2^20
  parameter int BLANK_CYCLES = 64      // trailing blank cycles per slot, < PRESCALE
) (
  input  logic       m_clock,
  input  logic       p_reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_pending,
  output logic       frame_done,
  output logic       sevenseg_select,
  output logic [6:0] sevenseg
);

  // Slot counter width is ceil-log2 of the slot length.
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] SLOT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_START = CW'(PRESCALE - BLANK_CYCLES);

  typedef enum logic {
    SHOW_LO = 1'b0,
    SHOW_HI = 1'b1
  } state_t;

  state_t          state;
  logic [CW-1:0]   slot_cnt;
  logic [7:0]      disp_reg;
  logic [7:0]      pend_reg;

  logic            slot_end;
  logic            frame_end;
  logic            in_blank;
  logic            lz_blank;
  logic [3:0]      cur_nibble;
  logic [6:0]      seg_next;

  // Hex to gfedcba segment pattern, active-high.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Slot/frame timing and the segment value the output register will take next.
  // Slot cycle 0 is blanked as well as the trailing interval, so the select
  // output always flips in a cycle whose segments are already dark.
  always_comb begin
    slot_end   = (slot_cnt == SLOT_LAST);
    frame_end  = slot_end && (state == SHOW_HI);
    in_blank   = (slot_cnt == '0) ||
                 ((BLANK_CYCLES > 0) && (slot_cnt >= BLANK_START));
    cur_nibble = (state == SHOW_HI) ? disp_reg[7:4] : disp_reg[3:0];
`ifdef SEVENSEG_LZB_EN
    // Suppress a leading zero on the tens digit; digit 0 always shows.
    lz_blank   = (state == SHOW_HI) && (disp_reg[7:4] == 4'h0);
`else
    lz_blank   = 1'b0;
`endif
    seg_next   = (in_blank || lz_blank) ? 7'h00 : hex_decode(cur_nibble);
  end

  // Scan FSM, slot counter, write capture and registered outputs.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      state           <= SHOW_LO;
      slot_cnt        <= '0;
      disp_reg        <= 8'h00;
      pend_reg        <= 8'h00;
      data_pending    <= 1'b0;
      frame_done      <= 1'b0;
      sevenseg_select <= 1'b0;
      sevenseg        <= 7'h00;
    end else begin
      // Counter wraps at the last cycle of a slot; the FSM only moves there.
      if (slot_end) begin
        slot_cnt <= '0;
        case (state)
          SHOW_LO: state <= SHOW_HI;
          default: state <= SHOW_LO;
        endcase
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end

      // Frame boundary: swap in the pending value (if any) and pulse frame_done.
      frame_done <= frame_end;
      if (frame_end) begin
        if (data_pending) begin
          disp_reg <= pend_reg;
        end
        data_pending <= 1'b0;
      end

      // A write always lands in the pending register; a write coinciding with
      // the boundary overrides the clear above and waits for the next frame.
      if (data_valid) begin
        pend_reg     <= data_in;
        data_pending <= 1'b1;
      end

      sevenseg_select <= (state == SHOW_HI);
      sevenseg        <= seg_next;
    end
  end

endmodule
